// File: rtl/vga_board_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_board_scheduler_pkg
//  Brief    : Shared timing constants, board geometry, FSM encoding and the
//             tile-difference helper for the VGA board scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_board_scheduler_pkg;

   localparam int c_VBP       = 31;
   localparam int c_VFP       = 511;
   localparam int c_TILE_W    = 16;
   localparam int c_NUM_TILES = 16;
   localparam int c_BOARD_W   = c_TILE_W * c_NUM_TILES;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   typedef logic [c_BOARD_W-1:0] board_t;

   // One bit per tile, set where the two boards hold different tile indices.
   function automatic logic [c_NUM_TILES-1:0] tile_diff(input board_t a, input board_t b);
      tile_diff = '0;
      for (int i = 0; i < c_NUM_TILES; i++) begin
         tile_diff[i] = (a[i*c_TILE_W +: c_TILE_W] != b[i*c_TILE_W +: c_TILE_W]);
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_board_scheduler_flash.sv
`default_nettype none
// ============================================================================
//  Module   : vga_flash_timer
//  Brief    : Per-tile frame down-counter; flag stays high until FLASH_FR
//             frame ticks have elapsed since the last load.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_flash_timer #(
   parameter int FLASH_FR = 8
) (
   input  logic dclk,
   input  logic clr_n,
   input  logic load,
   input  logic tick,
   output logic flag
);

   localparam int c_CW = $clog2(FLASH_FR + 1);

   logic [c_CW-1:0] r_cnt;

   // A reload wins over a decrement in the same cycle so a re-change restarts the count.
   always_ff @(posedge dclk) begin
      if (!clr_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= c_CW'(FLASH_FR);
      end else if (tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - c_CW'(1);
      end
   end

   assign flag = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/vga_board_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vga_board_scheduler
//  Brief    : Arbitrates game/init board updates into a pending buffer and
//             commits it to the renderer at the start of vertical blanking.
//             Optional changed-tile flash flags enabled by VGA_FLASH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_board_scheduler
   import vga_board_scheduler_pkg::*;
#(
   parameter int VBP   = c_VBP,
   parameter int VFP   = c_VFP,
   parameter int CNT_W = 8
`ifdef VGA_FLASH_EN
   ,
   parameter int FLASH_FR = 8
`endif
) (
   input  logic                   dclk,
   input  logic                   clr_n,
   input  logic [9:0]             vc,
   input  logic                   game_req,
   input  logic [c_BOARD_W-1:0]   game_board,
   output logic                   game_ack,
   input  logic                   init_req,
   input  logic [c_BOARD_W-1:0]   init_board,
   output logic                   init_ack,
   output logic [c_BOARD_W-1:0]   board_state,
   output logic                   pending,
   output logic                   frame_tick,
   output logic [CNT_W-1:0]       frame_cnt,
   output logic [c_NUM_TILES-1:0] tile_flash
);

   localparam logic [9:0] c_VBP_LINE = 10'(VBP);
   localparam logic [9:0] c_VFP_LINE = 10'(VFP);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_vblank;
   logic                 r_vblank_d;
   logic                 r_frame_tick;
   logic [CNT_W-1:0]     r_frame_cnt;
   logic                 w_init_vld;
   logic                 w_game_vld;
   logic                 w_cap_init;
   logic                 w_cap_game;
   logic                 w_commit;
   logic                 r_init_ack;
   logic                 r_game_ack;
   board_t               r_buffer;
   board_t               r_board_state;

   // ---------------------------------------------------------------------
   //  Vertical blanking edge detect and frame counter
   // ---------------------------------------------------------------------
   assign w_vblank = (vc < c_VBP_LINE) || (vc >= c_VFP_LINE);

   // vblank_d starts high so the reset-time blanking interval does not tick.
   always_ff @(posedge dclk) begin
      if (!clr_n) begin
         r_vblank_d   <= 1'b1;
         r_frame_tick <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_vblank_d   <= w_vblank;
         r_frame_tick <= w_vblank & ~r_vblank_d;
         if (r_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   //  Arbiter / FSM
   // ---------------------------------------------------------------------
   // The ack cycle still sees the old req high; it must not be taken as a new board.
   assign w_init_vld = init_req & ~r_init_ack;
   assign w_game_vld = game_req & ~r_game_ack;

   always_ff @(posedge dclk) begin
      if (!clr_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cap_init  = 1'b0;
      w_cap_game  = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_init_vld) begin
               w_cap_init  = 1'b1;
               w_state_nxt = ST_PEND;
            end else if (w_game_vld) begin
               w_cap_game  = 1'b1;
               w_state_nxt = ST_PEND;
            end
         end
         ST_PEND: begin
            // Commit has priority; a request in the tick cycle waits for IDLE.
            if (r_frame_tick) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_init_vld) begin
               w_cap_init  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   //  Pending buffer, committed board and acknowledges
   // ---------------------------------------------------------------------
   always_ff @(posedge dclk) begin
      if (!clr_n) begin
         r_buffer      <= '0;
         r_board_state <= '0;
         r_init_ack    <= 1'b0;
         r_game_ack    <= 1'b0;
      end else begin
         r_init_ack <= w_cap_init;
         r_game_ack <= w_cap_game;
         if (w_cap_init) begin
            r_buffer <= init_board;
         end else if (w_cap_game) begin
            r_buffer <= game_board;
         end
         if (w_commit) begin
            r_board_state <= r_buffer;
         end
      end
   end

   assign game_ack    = r_game_ack;
   assign init_ack    = r_init_ack;
   assign board_state = r_board_state;
   assign pending     = (r_state == ST_PEND);
   assign frame_tick  = r_frame_tick;
   assign frame_cnt   = r_frame_cnt;

   // ---------------------------------------------------------------------
   //  Changed-tile flash flags
   // ---------------------------------------------------------------------
`ifdef VGA_FLASH_EN
   logic [c_NUM_TILES-1:0] w_tile_changed;
   logic [c_NUM_TILES-1:0] w_flash;

   assign w_tile_changed = tile_diff(r_board_state, r_buffer);

   genvar gi;
   generate
      for (gi = 0; gi < c_NUM_TILES; gi++) begin : g_flash
         vga_flash_timer #(
            .FLASH_FR (FLASH_FR)
         ) u_flash_timer (
            .dclk  (dclk),
            .clr_n (clr_n),
            .load  (w_commit & w_tile_changed[gi]),
            .tick  (r_frame_tick),
            .flag  (w_flash[gi])
         );
      end
   endgenerate

   assign tile_flash = w_flash;
`else
   assign tile_flash = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_board_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_board_scheduler
//  Brief    : Scoreboard bench for vga_board_scheduler: directed stimulus
//             pushes expected acks/ticks, a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_board_scheduler;

   typedef struct {
      bit           is_init;
      logic [255:0] board;
   } ack_t;

   typedef struct {
      logic [7:0]   cnt;
      logic [255:0] board;
      logic [15:0]  flash;
   } tick_t;

   logic         dclk = 1'b0;
   logic         clr_n;
   logic [9:0]   vc;
   logic         game_req;
   logic [255:0] game_board;
   logic         game_ack;
   logic         init_req;
   logic [255:0] init_board;
   logic         init_ack;
   logic [255:0] board_state;
   logic         pending;
   logic         frame_tick;
   logic [7:0]   frame_cnt;
   logic [15:0]  tile_flash;

   int    checks = 0;
   int    errors = 0;
   ack_t  ack_q[$];
   tick_t tick_q[$];

   always #20 dclk = ~dclk;

   vga_board_scheduler #(
      .VBP   (31),
      .VFP   (511),
      .CNT_W (8)
`ifdef VGA_FLASH_EN
      ,
      .FLASH_FR (2)
`endif
   ) dut (
      .dclk        (dclk),
      .clr_n       (clr_n),
      .vc          (vc),
      .game_req    (game_req),
      .game_board  (game_board),
      .game_ack    (game_ack),
      .init_req    (init_req),
      .init_board  (init_board),
      .init_ack    (init_ack),
      .board_state (board_state),
      .pending     (pending),
      .frame_tick  (frame_tick),
      .frame_cnt   (frame_cnt),
      .tile_flash  (tile_flash)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] fx(input logic [15:0] v);
`ifdef VGA_FLASH_EN
      fx = v;
`else
      fx = v & 16'h0;
`endif
   endfunction

   function automatic logic [255:0] mk(input int i, input logic [15:0] v, input logic [255:0] base);
      logic [255:0] r;
      r = base;
      r[i*16 +: 16] = v;
      return r;
   endfunction

   // Monitor: one sample per cycle, 1 time unit after the rising edge.
   initial begin : monitor
      tick_t pt;
      ack_t  pa;
      bit    post_due;
      post_due = 1'b0;
      forever begin
         @(posedge dclk);
         #1;
         if (!clr_n) begin
            post_due = 1'b0;
         end else begin
            if (post_due) begin
               chk("commit_board", board_state, pt.board);
               chk("commit_pending", {255'd0, pending}, 256'd0);
               chk("commit_frame_cnt", {248'd0, frame_cnt}, {248'd0, pt.cnt} + 256'd1);
               chk("tile_flash", {240'd0, tile_flash}, {240'd0, pt.flash});
               post_due = 1'b0;
            end
            if (game_ack || init_ack) begin
               if (ack_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ack actual=game%0b_init%0b required=none vc=%0d",
                           game_ack, init_ack, vc);
               end else begin
                  pa = ack_q.pop_front();
                  chk("ack_init", {255'd0, init_ack}, {255'd0, pa.is_init});
                  chk("ack_game", {255'd0, game_ack}, {255'd0, !pa.is_init});
                  chk("ack_pending", {255'd0, pending}, 256'd1);
                  chk("ack_board_state", board_state, pa.board);
               end
            end
            if (frame_tick) begin
               if (tick_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_tick actual=vc%0d required=none", vc);
               end else begin
                  pt = tick_q.pop_front();
                  chk("tick_vc", {246'd0, vc}, 256'd511);
                  chk("tick_frame_cnt", {248'd0, frame_cnt}, {248'd0, pt.cnt});
                  post_due = 1'b1;
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge dclk);
      vc = (vc == 10'd520) ? 10'd0 : vc + 10'd1;
   endtask

   task automatic run_to(input int v);
      do step(); while (vc != 10'(v));
   endtask

   task automatic push_ack(input bit is_init, input logic [255:0] board);
      ack_t a;
      a.is_init = is_init;
      a.board   = board;
      ack_q.push_back(a);
   endtask

   task automatic frame(input logic [7:0] cnt, input logic [255:0] board, input logic [15:0] flash);
      tick_t t;
      t.cnt   = cnt;
      t.board = board;
      t.flash = flash;
      tick_q.push_back(t);
      run_to(511);
      run_to(520);
   endtask

   // Requester model: drop each req in the cycle after its ack; bounded wait.
   task automatic wait_acks(input bit need_init, input bit need_game, input int maxc);
      int n;
      n = 0;
      while (((need_init && init_req) || (need_game && game_req)) && n < maxc) begin
         step();
         n++;
         if (init_req && init_ack) init_req = 1'b0;
         if (game_req && game_ack) game_req = 1'b0;
      end
      checks++;
      if ((need_init && init_req) || (need_game && game_req)) begin
         errors++;
         $display("FAIL ack_timeout actual=no_ack required=ack init_req=%0b game_req=%0b",
                  init_req, game_req);
         init_req = 1'b0;
         game_req = 1'b0;
      end
   endtask

   initial begin : stimulus
      logic [255:0] b1, ia, ib, g, g2, g3, g4;
      b1 = mk(0, 16'h0001, 256'd0);
      ia = mk(3, 16'h0044, b1);
      ib = mk(5, 16'h0003, b1);
      g  = mk(7, 16'h0077, b1);
      g2 = mk(15, 16'h00F0, mk(0, 16'h0002, g));
      g3 = mk(15, 16'h00F1, mk(0, 16'h0003, g2));
      g4 = '1;

      clr_n = 1'b0; vc = '0; game_req = 1'b0; init_req = 1'b0;
      game_board = '0; init_board = '0;
      repeat (3) @(negedge dclk);
      chk("rst_board_state", board_state, 256'd0);
      chk("rst_pending", {255'd0, pending}, 256'd0);
      chk("rst_frame_cnt", {248'd0, frame_cnt}, 256'd0);
      chk("rst_frame_tick", {255'd0, frame_tick}, 256'd0);
      chk("rst_acks", {254'd0, game_ack, init_ack}, 256'd0);
      chk("rst_tile_flash", {240'd0, tile_flash}, 256'd0);
      clr_n = 1'b1;

      // Two idle frames
      frame(8'd0, 256'd0, 16'h0);
      frame(8'd1, 256'd0, 16'h0);
      chk("frame_cnt_two_frames", {248'd0, frame_cnt}, 256'd2);
      chk("board_idle_two_frames", board_state, 256'd0);

      // Game board mid-frame; held back until vblank
      run_to(100);
      push_ack(1'b0, 256'd0);
      game_board = b1; game_req = 1'b1;
      wait_acks(1'b0, 1'b1, 10);
      run_to(300);
      chk("midframe_board_held", board_state, 256'd0);
      chk("midframe_pending", {255'd0, pending}, 256'd1);
      frame(8'd2, b1, fx(16'h0001));

      // Simultaneous requests; init wins, then overwrites buffer while game waits
      run_to(100);
      push_ack(1'b1, b1);
      push_ack(1'b1, b1);
      push_ack(1'b0, ib);
      init_board = ia; init_req = 1'b1;
      game_board = g;  game_req = 1'b1;
      wait_acks(1'b1, 1'b0, 10);
      run_to(200);
      init_board = ib; init_req = 1'b1;
      wait_acks(1'b1, 1'b0, 10);
      begin
         tick_t t;
         t.cnt = 8'd3; t.board = ib; t.flash = fx(16'h0021);
         tick_q.push_back(t);
      end
      wait_acks(1'b0, 1'b1, 700);

      // Game request raised in the tick cycle of a pending commit
      begin
         tick_t t;
         t.cnt = 8'd4; t.board = g; t.flash = fx(16'h00A0);
         tick_q.push_back(t);
      end
      run_to(512);
      push_ack(1'b0, g);
      game_board = g2; game_req = 1'b1;
      wait_acks(1'b0, 1'b1, 10);
      frame(8'd5, g2, fx(16'h80A1));
      frame(8'd6, g2, fx(16'h8001));
      frame(8'd7, g2, fx(16'h0000));

      // Flash of tiles 0 and 15 only
      run_to(100);
      push_ack(1'b1, g2);
      init_board = g3; init_req = 1'b1;
      wait_acks(1'b1, 1'b0, 10);
      frame(8'd8,  g3, fx(16'h8001));
      frame(8'd9,  g3, fx(16'h8001));
      frame(8'd10, g3, fx(16'h0000));

      // Reset while a board is pending, with a request held through reset
      run_to(100);
      push_ack(1'b0, g3);
      game_board = g4; game_req = 1'b1;
      wait_acks(1'b0, 1'b1, 10);
      run_to(200);
      clr_n = 1'b0; game_req = 1'b1;
      repeat (3) step();
      chk("midpend_rst_board", board_state, 256'd0);
      chk("midpend_rst_pending", {255'd0, pending}, 256'd0);
      chk("midpend_rst_frame_cnt", {248'd0, frame_cnt}, 256'd0);
      chk("midpend_rst_flash", {240'd0, tile_flash}, 256'd0);
      game_req = 1'b0; clr_n = 1'b1;
      frame(8'd0, 256'd0, 16'h0);

      repeat (4) step();
      chk("ack_queue_drained", 256'(ack_q.size()), 256'd0);
      chk("tick_queue_drained", 256'(tick_q.size()), 256'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
